// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry (main + skid) elastic buffer and
// branch/jump resolution. Redirects are resolved at acceptance and reported
// as a single-cycle BRANCH_TAKEN pulse, independent of downstream backpressure.
module ex_mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] ALU_RESULT,
  input  logic            ZERO,
  input  logic            SIGN,
  input  logic            SLTU,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] IMM,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic [3:0]      CTRL,
  input  logic [2:0]      FUNCT3,
  input  logic [4:0]      RD_ADDR,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_RESULT,
  output logic [XLEN-1:0] OUT_RS2,
  output logic [4:0]      OUT_RD,
  output logic [2:0]      OUT_FUNCT3,
  output logic            OUT_REG_WRITE,
  output logic            BRANCH_TAKEN,
  output logic [XLEN-1:0] BRANCH_TARGET
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            reg_write;
  } bundle_t;

  // Control decode: CTRL = {BRANCH, JAL, JALR, REG_WRITE}
  logic is_branch;
  logic is_jal;
  logic is_jalr;
  logic is_jump;

  assign is_branch = CTRL[3];
  assign is_jal    = CTRL[2];
  assign is_jalr   = CTRL[1];
  assign is_jump   = is_jal | is_jalr;

  logic            br_cond;
  logic            redirect;
  logic [XLEN-1:0] target_calc;
  bundle_t         in_bundle;
  logic            accept;

  bundle_t         main_q, main_d;
  bundle_t         skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;

  // Branch condition selected by FUNCT3; 010/011 are never taken
  always_comb begin
    br_cond = 1'b0;
    unique case (FUNCT3)
      3'b000:  br_cond = ZERO;
      3'b001:  br_cond = ~ZERO;
      3'b100:  br_cond = SIGN;
      3'b101:  br_cond = ~SIGN;
      3'b110:  br_cond = SLTU;
      3'b111:  br_cond = ~SLTU;
      default: br_cond = 1'b0;
    endcase
  end

  // Redirect decision, target and the bundle to be captured
  always_comb begin
    redirect    = is_jump | (is_branch & br_cond);
    target_calc = is_jalr ? {ALU_RESULT[XLEN-1:1], 1'b0} : PC + IMM;

    in_bundle.result    = is_jump ? PC + XLEN'(4) : ALU_RESULT;
    in_bundle.rs2       = RS2_DATA;
    in_bundle.rd        = RD_ADDR;
    in_bundle.funct3    = FUNCT3;
    in_bundle.reg_write = CTRL[0];
  end

  // Ready depends only on the registered skid state
  assign IN_READY = ~skid_valid_q;
  assign accept   = IN_VALID & ~skid_valid_q;

  // Next-state for the main/skid buffer and the redirect pulse; FLUSH wins
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    taken_d      = 1'b0;
    target_d     = target_q;

    if (FLUSH) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (skid_valid_q) begin
        // Skid full implies no acceptance this edge; only a skid->main move.
        if (OUT_READY) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (!main_valid_q || OUT_READY) begin
          main_d       = in_bundle;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = in_bundle;
          skid_valid_d = 1'b1;
        end
      end else if (OUT_READY) begin
        main_valid_d = 1'b0;
      end

      if (accept && redirect) begin
        taken_d  = 1'b1;
        target_d = target_calc;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
    end
  end

  assign OUT_VALID     = main_valid_q;
  assign OUT_RESULT    = main_q.result;
  assign OUT_RS2       = main_q.rs2;
  assign OUT_RD        = main_q.rd;
  assign OUT_FUNCT3    = main_q.funct3;
  assign OUT_REG_WRITE = main_q.reg_write;
  assign BRANCH_TAKEN  = taken_q;
  assign BRANCH_TARGET = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the stage is modelled as an ordered
// store of at most two bundles plus a one-cycle redirect flag.
module tb_ex_mem_stage;

  logic        CLK;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] ALU_RESULT;
  logic        ZERO;
  logic        SIGN;
  logic        SLTU;
  logic [31:0] PC;
  logic [31:0] IMM;
  logic [31:0] RS2_DATA;
  logic [3:0]  CTRL;
  logic [2:0]  FUNCT3;
  logic [4:0]  RD_ADDR;
  logic        FLUSH;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_RESULT;
  logic [31:0] OUT_RS2;
  logic [4:0]  OUT_RD;
  logic [2:0]  OUT_FUNCT3;
  logic        OUT_REG_WRITE;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;

  ex_mem_stage #(.XLEN(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IN_VALID      (IN_VALID),
    .IN_READY      (IN_READY),
    .ALU_RESULT    (ALU_RESULT),
    .ZERO          (ZERO),
    .SIGN          (SIGN),
    .SLTU          (SLTU),
    .PC            (PC),
    .IMM           (IMM),
    .RS2_DATA      (RS2_DATA),
    .CTRL          (CTRL),
    .FUNCT3        (FUNCT3),
    .RD_ADDR       (RD_ADDR),
    .FLUSH         (FLUSH),
    .OUT_VALID     (OUT_VALID),
    .OUT_READY     (OUT_READY),
    .OUT_RESULT    (OUT_RESULT),
    .OUT_RS2       (OUT_RS2),
    .OUT_RD        (OUT_RD),
    .OUT_FUNCT3    (OUT_FUNCT3),
    .OUT_REG_WRITE (OUT_REG_WRITE),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        rw;
  } exp_t;

  exp_t        sbq[$];
  logic        exp_pulse;
  logic [31:0] exp_target;
  int          n_cmp;
  int          n_mis;
  int          occ;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, evaluated from the current input values
  function automatic logic ref_taken();
    logic cond;
    case (FUNCT3)
      3'b000:  cond = ZERO;
      3'b001:  cond = !ZERO;
      3'b100:  cond = SIGN;
      3'b101:  cond = !SIGN;
      3'b110:  cond = SLTU;
      3'b111:  cond = !SLTU;
      default: cond = 1'b0;
    endcase
    return CTRL[2] || CTRL[1] || (CTRL[3] && cond);
  endfunction

  function automatic logic [31:0] ref_target();
    if (CTRL[1]) return ALU_RESULT & 32'hFFFF_FFFE;
    return PC + IMM;
  endfunction

  function automatic exp_t ref_bundle();
    exp_t e;
    e.result = (CTRL[2] || CTRL[1]) ? PC + 32'd4 : ALU_RESULT;
    e.rs2    = RS2_DATA;
    e.rd     = RD_ADDR;
    e.funct3 = FUNCT3;
    e.rw     = CTRL[0];
    return e;
  endfunction

  // Reference model: up to two bundles held in order, consumed on OUT_READY
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sbq.delete();
      exp_pulse  = 1'b0;
      exp_target = '0;
    end else begin
      occ       = sbq.size();
      exp_pulse = 1'b0;
      if (FLUSH) begin
        sbq.delete();
      end else begin
        if (OUT_READY && occ > 0) void'(sbq.pop_front());
        if (IN_VALID && occ < 2) begin
          sbq.push_back(ref_bundle());
          if (ref_taken()) begin
            exp_pulse  = 1'b1;
            exp_target = ref_target();
          end
        end
      end
    end
  end

  // Monitor: compare presented outputs against the scoreboard head
  always @(negedge CLK) begin
    if (RESET) begin
      check("in_ready", {31'd0, IN_READY}, {31'd0, sbq.size() < 2});
      check("out_valid", {31'd0, OUT_VALID}, {31'd0, sbq.size() > 0});
      if (OUT_VALID && sbq.size() > 0) begin
        mon_e = sbq[0];
        check("out_result", OUT_RESULT, mon_e.result);
        check("out_rs2", OUT_RS2, mon_e.rs2);
        check("out_rd", {27'd0, OUT_RD}, {27'd0, mon_e.rd});
        check("out_funct3", {29'd0, OUT_FUNCT3}, {29'd0, mon_e.funct3});
        check("out_reg_write", {31'd0, OUT_REG_WRITE}, {31'd0, mon_e.rw});
      end
      check("branch_taken", {31'd0, BRANCH_TAKEN}, {31'd0, exp_pulse});
      if (exp_pulse) check("branch_target", BRANCH_TARGET, exp_target);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ctrl, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                       input logic z, input logic s, input logic lt,
                       input logic [31:0] rs2, input logic [4:0] rd);
    IN_VALID   = v;
    CTRL       = ctrl;
    FUNCT3     = f3;
    PC         = pc;
    IMM        = imm;
    ALU_RESULT = alu;
    ZERO       = z;
    SIGN       = s;
    SLTU       = lt;
    RS2_DATA   = rs2;
    RD_ADDR    = rd;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, {31'd0, OUT_VALID}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, IN_READY}, 32'd1);
    check({tag, "_taken"}, {31'd0, BRANCH_TAKEN}, 32'd0);
    check({tag, "_target"}, BRANCH_TARGET, 32'd0);
    check({tag, "_result"}, OUT_RESULT, 32'd0);
    check({tag, "_rs2"}, OUT_RS2, 32'd0);
    check({tag, "_rd"}, {27'd0, OUT_RD}, 32'd0);
    check({tag, "_funct3"}, {29'd0, OUT_FUNCT3}, 32'd0);
    check({tag, "_reg_write"}, {31'd0, OUT_REG_WRITE}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    RESET = 1'b0;
    FLUSH = 1'b0;
    OUT_READY = 1'b1;
    drive(1'b0, 4'b0000, 3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #11;
    check_reset_values("por");

    // BEQ taken: target PC+IMM, one-cycle pulse
    #1;
    RESET = 1'b1;
    drive(1'b1, 4'b1000, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h11, 5'd0);
    step();
    check("beq_taken", {31'd0, BRANCH_TAKEN}, 32'd1);
    check("beq_target", BRANCH_TARGET, 32'h120);
    IN_VALID = 1'b0;
    step();
    check("beq_pulse_end", {31'd0, BRANCH_TAKEN}, 32'd0);

    // JALR: target with bit0 cleared, result PC+4
    drive(1'b1, 4'b0011, 3'b000, 32'h400, 32'h0, 32'h2003, 1'b0, 1'b0, 1'b0, 32'h22, 5'd5);
    step();
    check("jalr_target", BRANCH_TARGET, 32'h2002);
    check("jalr_result", OUT_RESULT, 32'h404);
    check("jalr_rw", {31'd0, OUT_REG_WRITE}, 32'd1);
    IN_VALID = 1'b0;
    step();

    // Backpressure: A main, B skid, C refused; then drain in order
    OUT_READY = 1'b0;
    drive(1'b1, 4'b0001, 3'b010, 32'h0, 32'h0, 32'hA, 1'b0, 1'b0, 1'b0, 32'hA0, 5'd1);
    step();
    drive(1'b1, 4'b0001, 3'b010, 32'h0, 32'h0, 32'hB, 1'b0, 1'b0, 1'b0, 32'hB0, 5'd2);
    step();
    drive(1'b1, 4'b0001, 3'b010, 32'h0, 32'h0, 32'hC, 1'b0, 1'b0, 1'b0, 32'hC0, 5'd3);
    step();
    check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
    check("bp_hold_a", OUT_RESULT, 32'hA);
    step();
    check("bp_hold_a2", OUT_RESULT, 32'hA);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    step();
    check("bp_out_b", OUT_RESULT, 32'hB);
    check("bp_ready_back", {31'd0, IN_READY}, 32'd1);
    step();
    check("bp_empty", {31'd0, OUT_VALID}, 32'd0);

    // FLUSH coincident with a taken BNE
    drive(1'b1, 4'b1000, 3'b001, 32'h300, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd4);
    FLUSH = 1'b1;
    step();
    check("flush_valid", {31'd0, OUT_VALID}, 32'd0);
    check("flush_taken", {31'd0, BRANCH_TAKEN}, 32'd0);
    check("flush_ready", {31'd0, IN_READY}, 32'd1);
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    step();

    // Non-taken branches pass through
    drive(1'b1, 4'b1001, 3'b010, 32'h500, 32'h8, 32'h55, 1'b1, 1'b1, 1'b1, 32'h0, 5'd6);
    step();
    check("f3_010_taken", {31'd0, BRANCH_TAKEN}, 32'd0);
    check("f3_010_result", OUT_RESULT, 32'h55);
    drive(1'b1, 4'b1000, 3'b110, 32'h600, 32'h8, 32'h66, 1'b1, 1'b1, 1'b0, 32'h0, 5'd7);
    step();
    check("bltu_taken", {31'd0, BRANCH_TAKEN}, 32'd0);
    check("bltu_result", OUT_RESULT, 32'h66);
    IN_VALID = 1'b0;
    step();

    // Asynchronous reset with both entries full and a pulse pending
    OUT_READY = 1'b0;
    drive(1'b1, 4'b0101, 3'b000, 32'h800, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h77, 5'd7);
    step();
    drive(1'b1, 4'b0101, 3'b000, 32'h900, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h88, 5'd8);
    step();
    IN_VALID = 1'b0;
    check("pre_rst_full", {31'd0, IN_READY}, 32'd0);
    check("pre_rst_taken", {31'd0, BRANCH_TAKEN}, 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    OUT_READY = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, 4'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom,
            1'($urandom), 1'($urandom), 1'($urandom), $urandom, 5'($urandom));
      OUT_READY = $urandom_range(0, 9) < 6;
      FLUSH     = $urandom_range(0, 24) == 0;
      step();
    end

    IN_VALID  = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
